// File: rtl/register_file_16x16_pkg.sv
// register_file_16x16_pkg: shared word width, register address width and RA register index
package register_file_16x16_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int RA_REG     = 15;
endpackage

// File: rtl/register_file_16x16.sv
// register_file_16x16: register array with a general read/write port and an aliased return-address port
module register_file_16x16
  import register_file_16x16_pkg::*;
#(
  parameter int DATA_W   = WORD_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int RA_INDEX = RA_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic [DATA_W-1:0] ra_din,
  input  logic              ra_we,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] ra_dout
);
  localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_INDEX);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  // register update; the general write is issued last so it wins a collision on the RA register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else begin
      if (ra_we) regs[RA_ADDR] <= ra_din;
      if (we) regs[addr] <= din;
    end
  assign dout    = regs[addr];
  assign ra_dout = regs[RA_ADDR];
endmodule

// File: tb/tb_register_file_16x16.sv
// tb_register_file_16x16: directed vectors checked through an expectation queue by an independent monitor
module tb_register_file_16x16;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic [15:0] din;
  logic        we;
  logic [15:0] ra_din;
  logic        ra_we;
  logic [15:0] dout;
  logic [15:0] ra_dout;

  typedef struct {
    string       name;
    bit          ra;
    int          idx;
    logic [15:0] exp;
  } item_t;

  item_t       q[$];
  int          pushed = 0;
  int          applied = 0;
  int          miscompares = 0;
  logic [15:0] m [16];

  register_file_16x16 dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we),
    .ra_din(ra_din), .ra_we(ra_we), .dout(dout), .ra_dout(ra_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit ra, input logic [15:0] exp);
    item_t it;
    it.name = name;
    it.ra   = ra;
    it.idx  = int'(addr);
    it.exp  = exp;
    q.push_back(it);
    pushed++;
    #1;
  endtask

  // monitor: whenever an expectation is queued, sample the selected output and compare
  initial begin
    item_t it;
    logic [15:0] act;
    forever begin
      wait (applied != pushed);
      it = q.pop_front();
      act = it.ra ? ra_dout : dout;
      applied++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s addr=%0d got=%h want=%h", it.name, it.idx, act, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; we = 1'b1; din = 16'h1234; addr = '0; ra_we = 1'b1; ra_din = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      expect_out("reset_dout", 1'b0, 16'h0000);
    end
    expect_out("reset_ra_dout", 1'b1, 16'h0000);
    we = 1'b0; ra_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int a = 0; a < 16; a++) m[a] = 16'h0000;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); we = 1'b1; din = 16'(a + 1);
      tick();
      m[a] = 16'(a + 1);
      expect_out("write", 1'b0, m[a]);
      we = 1'b0; din = 16'd50;
      tick();
      expect_out("hold", 1'b0, m[a]);
    end
    addr = 4'd5; we = 1'b1; din = 16'hBEEF;
    expect_out("no_bypass", 1'b0, m[5]);
    tick();
    we = 1'b0;
    m[5] = 16'hBEEF;
    expect_out("write_after_edge", 1'b0, m[5]);
    ra_we = 1'b1; ra_din = 16'd1;
    tick();
    ra_we = 1'b0;
    m[15] = 16'd1;
    expect_out("ra_write", 1'b1, 16'd1);
    addr = 4'd15;
    expect_out("ra_via_dout", 1'b0, 16'd1);
    addr = 4'd0;
    expect_out("ra_no_side_effect", 1'b0, m[0]);
    ra_din = 16'd100; we = 1'b1; addr = 4'd15; din = 16'd200;
    tick();
    we = 1'b0;
    m[15] = 16'd200;
    expect_out("alias_ra_dout", 1'b1, 16'd200);
    we = 1'b1; ra_we = 1'b1; addr = 4'd15; din = 16'd7; ra_din = 16'd9;
    tick();
    we = 1'b0; ra_we = 1'b0;
    m[15] = 16'd7;
    expect_out("collide_ra_dout", 1'b1, 16'd7);
    expect_out("collide_dout", 1'b0, 16'd7);
    we = 1'b1; ra_we = 1'b1; addr = 4'd3; din = 16'd7; ra_din = 16'd9;
    tick();
    we = 1'b0; ra_we = 1'b0;
    m[3] = 16'd7; m[15] = 16'd9;
    expect_out("dual_write_reg3", 1'b0, 16'd7);
    expect_out("dual_write_ra", 1'b1, 16'd9);
    tick();
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset_dout", 1'b0, 16'h0000);
    expect_out("async_reset_ra", 1'b1, 16'h0000);
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      expect_out("async_reset_sweep", 1'b0, 16'h0000);
    end
    reset = 1'b1;
    #2;
    if (applied != pushed) begin
      miscompares++;
      $display("FAIL drain got=%0d want=%0d", applied, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/register_file_16x16.md
REGISTER_FILE_16X16 -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and data-port width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; register count is 2**ADDR_W (16).
REQ-003 SHALL have parameter RA_INDEX, default 15, register index aliased by the return-address (RA) port.
REQ-004 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 SHALL have addr  input  ADDR_W  register select for the general read/write port.
REQ-007 SHALL have din  input  DATA_W  general-port write data.
REQ-008 SHALL have we  input  1  general-port write enable.
REQ-009 SHALL have ra_din  input  DATA_W  RA-port write data.
REQ-010 SHALL have ra_we  input  1  RA-port write enable.
REQ-011 SHALL have dout  output  DATA_W  contents of register[addr].
REQ-012 SHALL have ra_dout  output  DATA_W  contents of register[RA_INDEX].

Function
REQ-013 SHALL hold 2**ADDR_W registers of DATA_W bits each; all registers, including index 0, are writable (no hard-wired zero).
REQ-014 SHALL drive dout combinationally from register[addr]; an addr change is reflected with no clock latency.
REQ-015 SHALL drive ra_dout combinationally from register[RA_INDEX].
REQ-016 SHALL, on a rising clk edge with we=1, load din into register[addr]; the new value is visible on dout after that edge (one-edge write latency, no write-through bypass before the edge).
REQ-017 SHALL, on a rising clk edge with ra_we=1, load ra_din into register[RA_INDEX].
REQ-018 SHALL leave all registers unchanged when we=0 and ra_we=0, regardless of din/ra_din.
REQ-019 SHALL, when we=1 and ra_we=1 on the same edge with addr=RA_INDEX, store din (general port has priority).
REQ-020 SHALL, when we=1 and ra_we=1 with addr!=RA_INDEX, perform both writes on the same edge.
REQ-021 SHALL, when a general-port write to RA_INDEX occurs, update ra_dout as well as dout after the edge.

Reset
REQ-022 SHALL clear every register to 0 immediately when reset goes low, independent of clk.
REQ-023 SHALL hold all registers at 0 and ignore we/ra_we while reset is low; dout and ra_dout read 0.
REQ-024 SHALL resume normal writes at the first rising clk edge after reset returns high.

Structure
REQ-025 SHALL take DATA_W, ADDR_W and RA_INDEX defaults from the shared project package (e.g. WORD_W=16, REG_ADDR_W=4, RA_REG=15).
REQ-026 SHALL be implemented as a single module (register array plus write-decode and read mux); no sub-module is required.

Verification
REQ-027 SHALL verify reset: reset low with we=1, din=16'h1234 -> dout=0 and ra_dout=0 for every addr.
REQ-028 SHALL verify write/hold per register: for addr=0..15, we=1, din=addr+1, one clk -> dout=addr+1; then we=0, din=50, one clk -> dout unchanged.
REQ-029 SHALL verify RA port: ra_we=1, ra_din=1, one clk -> ra_dout=1, dout at addr=15 reads 1, dout at addr=0 unaffected.
REQ-030 SHALL verify aliasing: ra_we=0, ra_din=100, we=1, addr=15, din=200, one clk -> ra_dout=200.
REQ-031 SHALL verify collision: we=1, ra_we=1, addr=15, din=7, ra_din=9, one clk -> ra_dout=7; with addr=3 instead -> register 3=7, ra_dout=9.
REQ-032 SHALL verify async reset mid-operation: after loading nonzero values, assert reset low between clock edges -> all outputs 0 before the next rising edge.
